// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and RCON lookup for the AES-128 key schedule controller.
package aes_pkg;

  localparam int KEY_L = 128;
  localparam int WORD  = 32;
  localparam int NR    = 10;
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_FINISH = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  // RCON word for round r: the round constant byte in the top byte, zeros below.
  function automatic logic [WORD-1:0] rcon_word(input logic [IDX_W-1:0] r);
    logic [7:0] b;
    case (r)
      4'd1:    b = 8'h01;
      4'd2:    b = 8'h02;
      4'd3:    b = 8'h04;
      4'd4:    b = 8'h08;
      4'd5:    b = 8'h10;
      4'd6:    b = 8'h20;
      4'd7:    b = 8'h40;
      4'd8:    b = 8'h80;
      4'd9:    b = 8'h1b;
      4'd10:   b = 8'h36;
      default: b = 8'h00;
    endcase
    return {b, 24'h0};
  endfunction

endpackage

// File: rtl/aes_key_store.sv
// NR+1 entry round-key store: one write port, one registered read port gated by en.
module aes_key_store
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [KEY_L-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_addr_i,
  output logic [KEY_L-1:0] rd_key_o,
  output logic             rd_valid_o
);

  logic [KEY_L-1:0] mem_q [NR+1];
  logic [KEY_L-1:0] rd_key_q;
  logic             rd_valid_q;
  logic             rd_hit_d;

  assign rd_hit_d = rd_en_i && (rd_addr_i <= IDX_W'(NR));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= NR; i++) mem_q[i] <= '0;
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (we_i && (wr_addr_i <= IDX_W'(NR))) mem_q[wr_addr_i] <= wr_data_i;
      rd_valid_q <= rd_hit_d;
      rd_key_q   <= rd_hit_d ? mem_q[rd_addr_i] : '0;
    end
  end

  assign rd_key_o   = rd_key_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// Drives the external round-key unit through NR rounds and keeps every round key
// in a store readable by round index with one cycle of latency.
//
//   state  | meaning
//   IDLE   | waiting for start; keys_ready reflects the last completed run
//   ISSUE  | one-cycle strobe of kg_key/kg_rcon to the key unit
//   WAIT   | waiting for kg_valid_out, bounded by MAX_WAIT
//   FINISH | one-cycle done pulse, keys become ready
//   ERROR  | key unit timed out; left only by start
module aes_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_L-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic             keys_ready,
  output logic             err,
  output logic             kg_valid_in,
  output logic [KEY_L-1:0] kg_key,
  output logic [WORD-1:0]  kg_rcon,
  input  logic [KEY_L-1:0] kg_round_key,
  input  logic             kg_valid_out,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [KEY_L-1:0] rd_key,
  output logic             rd_valid
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  state_t            state_q;
  logic [IDX_W-1:0]  round_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              busy_q, done_q, keys_ready_q, err_q, kg_valid_in_q;
  logic [KEY_L-1:0]  kg_key_q;
  logic [WORD-1:0]   kg_rcon_q;

  logic              start_ok_d, wr_res_d;
  logic              st_we_d;
  logic [IDX_W-1:0]  st_addr_d;
  logic [KEY_L-1:0]  st_data_d;

  assign start_ok_d = start && ((state_q == S_IDLE) || (state_q == S_ERROR));
  assign wr_res_d   = kg_valid_out && (state_q == S_WAIT);

  always_comb begin
    st_we_d   = 1'b0;
    st_addr_d = '0;
    st_data_d = key_in;
    if (start_ok_d) begin
      st_we_d = 1'b1;
    end else if (wr_res_d) begin
      st_we_d   = 1'b1;
      st_addr_d = round_q;
      st_data_d = kg_round_key;
    end
  end

  // kg_key/kg_rcon are loaded on the edge that enters ISSUE, so the result just
  // written to store[round] is forwarded directly instead of read back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      round_q       <= '0;
      wcnt_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      keys_ready_q  <= 1'b0;
      err_q         <= 1'b0;
      kg_valid_in_q <= 1'b0;
      kg_key_q      <= '0;
      kg_rcon_q     <= '0;
    end else begin
      kg_valid_in_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (start) begin
            round_q       <= IDX_W'(1);
            keys_ready_q  <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b1;
            kg_key_q      <= key_in;
            kg_rcon_q     <= rcon_word(IDX_W'(1));
            kg_valid_in_q <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (kg_valid_out) begin
            if (round_q == IDX_W'(NR)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              round_q       <= round_q + IDX_W'(1);
              kg_key_q      <= kg_round_key;
              kg_rcon_q     <= rcon_word(round_q + IDX_W'(1));
              kg_valid_in_q <= 1'b1;
              state_q       <= S_ISSUE;
            end
          end else if (wcnt_q == WCNT_W'(MAX_WAIT - 1)) begin
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        S_FINISH: begin
          keys_ready_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  aes_key_store u_store (
    .clk        (clk),
    .reset      (reset),
    .we_i       (st_we_d),
    .wr_addr_i  (st_addr_d),
    .wr_data_i  (st_data_d),
    .rd_en_i    (keys_ready_q),
    .rd_addr_i  (rd_addr),
    .rd_key_o   (rd_key),
    .rd_valid_o (rd_valid)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign keys_ready  = keys_ready_q;
  assign err         = err_q;
  assign kg_valid_in = kg_valid_in_q;
  assign kg_key      = kg_key_q;
  assign kg_rcon     = kg_rcon_q;

endmodule
